pipeline_trace_buffer: RTL and testbench
========================================

// Module: pipeline_trace_buffer
// PURPOSE
//  Synthesizable, parametrised pipeline trace capture for the ARM pipeline CPU.
//  Each enabled cycle it samples the PC and per-stage control snapshots (ID/EX/MEM/WB) into a circular buffer.
//  It stops on a trigger plus a programmable post-trigger count, then drains frozen entries oldest-first via valid/ready.
// PARAMETERS
//  PC_W        32  PC width
//  SNAP_W      16  control-snapshot width per stage
//  NUM_STAGES  4   stages sampled (0=ID .. 3=WB)
//  DEPTH       16  buffer entries; power of two, >=4
//  CYC_W       16  cycle-stamp width (used only with TRACE_TIMESTAMP_EN)
// PORTS
//  clk         in   1                      clock; one clock; all logic on posedge
//  reset       in   1                      one clock; reset is asynchronous and active-low
//  enable      in   1                      capture qualifier; 0 = stalled cycle, not recorded
//  pc          in   PC_W                   fetch PC this cycle
//  stage_snap  in   NUM_STAGES*SNAP_W      stage k at [k*SNAP_W +: SNAP_W]
//  arm         in   1                      pulse: start capture (IDLE only)
//  abort       in   1                      pulse: return to IDLE, discard buffer
//  trig_mode   in   2                      00 immediate, 01 pc==trig_pc, 10 snap match, 11 never
//  trig_pc     in   PC_W                   PC compare value
//  trig_mask   in   SNAP_W                 stage-0 snapshot mask (mode 10)
//  trig_val    in   SNAP_W                 stage-0 compare value (mode 10)
//  post_count  in   $clog2(DEPTH)          entries to record after trigger entry
//  rd_valid    out  1                      entry available
//  rd_ready    in   1                      consumer accepts
//  rd_data     out  RD_W                   {stamp?, pc, stage_snap}; RD_W from macro
//  state       out  2                      0 IDLE, 1 ARMED, 2 POST, 3 DRAIN
//  count       out  $clog2(DEPTH)+1        valid entries held
//  triggered   out  1                      sticky from trigger until IDLE
// BEHAVIOUR
//  - reset low: state=IDLE, wr_ptr=rd_ptr=count=0, rd_valid=0, triggered=0, rd_data=0, stamp=0.
//  - IDLE: no capture. arm=1 -> ARMED next edge; count cleared. Trigger not evaluated in arm cycle.
//  - ARMED: each enable=1 cycle write entry at wr_ptr, wr_ptr+1 (mod DEPTH); count saturates at DEPTH
//    (oldest overwritten, rd_ptr follows). If trigger true on an enable=1 cycle: that sample is written,
//    triggered=1; post_count==0 -> DRAIN, else -> POST with remaining=post_count.
//    enable=0 cycles: nothing written, trigger ignored.
//  - POST: each enable=1 write decrements remaining; write with remaining==1 -> DRAIN same edge.
//    post_count >= DEPTH clamps to DEPTH-1 so the trigger entry is never overwritten.
//  - DRAIN: buffer frozen, inputs ignored. rd_valid=(count!=0); rd_data=mem[rd_ptr] registered,
//    valid one cycle after entering DRAIN. Transfer on rd_valid&&rd_ready: rd_ptr+1, count-1;
//    back-to-back pops at full rate. count reaching 0 -> IDLE, triggered cleared.
//  - abort (any state) -> IDLE next edge, count=0, rd_valid=0; abort wins over arm/trigger same cycle.
//  - arm outside IDLE ignored. Pointers wrap modulo DEPTH; stamp wraps modulo 2^CYC_W.
//  - Latency: sample at edge N readable no earlier than N+1.
// CONFIGURATION
//  TRACE_TIMESTAMP_EN defined: free-running stamp (+1 every clk, incl. enable=0) stored per entry;
//    RD_W = CYC_W+PC_W+NUM_STAGES*SNAP_W, stamp in MSBs.
//  Undefined: no counter, RD_W = PC_W+NUM_STAGES*SNAP_W; all else identical.
// STRUCTURE
//  pipeline_trace_pkg: state encodings (ST_IDLE..ST_DRAIN), trigger-mode constants (TRIG_IMM,
//    TRIG_PC, TRIG_SNAP, TRIG_NEVER), stage index constants (STG_ID, STG_EX, STG_MEM, STG_WB).
//  Sub-module trace_ram: simple dual-port DEPTH x ENTRY_W, sync write, registered read; FSM,
//    pointers, trigger compare in top.
// TESTING
//  1 reset low mid-POST with count=7 -> state=0, count=0, rd_valid=0 immediately (async).
//  2 mode 00, post_count=3, 4 enabled cycles pc=0,4,8,C -> DRAIN, 4 pops give pc 0,4,8,C, then IDLE.
//  3 mode 01 trig_pc=0x40, DEPTH=16, 30 enabled cycles before match, post_count=5 -> count=16,
//    entries = 10 pre-trigger, 0x40, 5 post, oldest first.
//  4 mode 10 mask=0x00F0 val=0x0030, enable toggling 1/0 -> only enable=1 samples stored;
//    matching snapshot during enable=0 does not trigger.
//  5 DRAIN with rd_ready random 50% -> no entry lost/duplicated; abort mid-drain -> IDLE, rd_valid=0.
//  6 TRACE_TIMESTAMP_EN defined, enable 1,0,0,1 -> consecutive entry stamps differ by 3.

Source files
------------

// File: rtl/pipeline_trace_pkg.sv
// Shared encodings for the pipeline trace buffer: FSM states, trigger modes
// and stage indices within the packed stage_snap bus.
package pipeline_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DRAIN = 2'd3
  } trace_state_t;

  localparam logic [1:0] TRIG_IMM   = 2'b00;
  localparam logic [1:0] TRIG_PC    = 2'b01;
  localparam logic [1:0] TRIG_SNAP  = 2'b10;
  localparam logic [1:0] TRIG_NEVER = 2'b11;

  localparam int STG_ID  = 0;
  localparam int STG_EX  = 1;
  localparam int STG_MEM = 2;
  localparam int STG_WB  = 3;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: synchronous write, registered read with
// read enable so the output holds steady while the consumer stalls.
module trace_ram #(
  parameter int W     = 96,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    rdata_o <= '0;
    else if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/pipeline_trace_buffer.sv
// Pipeline trace capture: circular buffer of PC + stage snapshots, stop on
// trigger + post count, then drain oldest-first. TRACE_TIMESTAMP_EN adds a cycle stamp.
module pipeline_trace_buffer
  import pipeline_trace_pkg::*;
#(
  parameter int PC_W       = 32,
  parameter int SNAP_W     = 16,
  parameter int NUM_STAGES = 4,
  parameter int DEPTH      = 16,
  parameter int CYC_W      = 16,
  localparam int AW        = $clog2(DEPTH),
`ifdef TRACE_TIMESTAMP_EN
  localparam int RD_W      = CYC_W + PC_W + NUM_STAGES * SNAP_W
`else
  localparam int RD_W      = PC_W + NUM_STAGES * SNAP_W
`endif
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [PC_W-1:0]              pc,
  input  logic [NUM_STAGES*SNAP_W-1:0] stage_snap,
  input  logic                         arm,
  input  logic                         abort,
  input  logic [1:0]                   trig_mode,
  input  logic [PC_W-1:0]              trig_pc,
  input  logic [SNAP_W-1:0]            trig_mask,
  input  logic [SNAP_W-1:0]            trig_val,
  input  logic [AW-1:0]                post_count,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [RD_W-1:0]              rd_data,
  output logic [1:0]                   state,
  output logic [AW:0]                  count,
  output logic                         triggered
);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pipeline_trace_buffer: DEPTH must be a power of two >= 4");
  end
  if (CYC_W < 1) begin : g_bad_cyc_w
    $error("pipeline_trace_buffer: CYC_W must be >= 1");
  end

  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  trace_state_t    state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [AW-1:0]   remaining_q, remaining_d;
  logic            triggered_q, triggered_d;
  logic            rd_valid_q, rd_valid_d;
  logic            trig_hit;
  logic            ram_we, ram_re;
  logic [AW-1:0]   ram_raddr;
  logic [RD_W-1:0] ram_wdata;
  logic [SNAP_W-1:0] id_snap;

  assign id_snap = stage_snap[STG_ID*SNAP_W +: SNAP_W];

`ifdef TRACE_TIMESTAMP_EN
  logic [CYC_W-1:0] stamp_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stamp_q <= '0;
    else        stamp_q <= stamp_q + CYC_W'(1);
  end
  assign ram_wdata = {stamp_q, pc, stage_snap};
`else
  assign ram_wdata = {pc, stage_snap};
`endif

  always_comb begin
    trig_hit = 1'b0;
    unique case (trig_mode)
      TRIG_IMM:   trig_hit = 1'b1;
      TRIG_PC:    trig_hit = (pc == trig_pc);
      TRIG_SNAP:  trig_hit = ((id_snap & trig_mask) == (trig_val & trig_mask));
      TRIG_NEVER: trig_hit = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    remaining_d = remaining_q;
    triggered_d = triggered_q;
    rd_valid_d  = 1'b0;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    ram_raddr   = rd_ptr_q;

    // Shared capture path; when full the oldest entry is dropped by advancing rd_ptr.
    if ((state_q == ST_ARMED || state_q == ST_POST) && enable) begin
      ram_we   = 1'b1;
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (count_q == FULL) rd_ptr_d = rd_ptr_q + AW'(1);
      else                 count_d  = count_q + (AW + 1)'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d  = ST_ARMED;
          count_d  = '0;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
        end
      end
      ST_ARMED: begin
        // post_count is only AW bits wide, so it can never exceed DEPTH-1 and the
        // trigger entry always survives until drain.
        if (enable && trig_hit) begin
          triggered_d = 1'b1;
          if (post_count == '0) begin
            state_d = ST_DRAIN;
          end else begin
            state_d     = ST_POST;
            remaining_d = post_count;
          end
        end
      end
      ST_POST: begin
        if (enable) begin
          remaining_d = remaining_q - AW'(1);
          if (remaining_q == AW'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        ram_re = 1'b1;
        if (rd_valid_q && rd_ready) begin
          rd_ptr_d = rd_ptr_q + AW'(1);
          count_d  = count_q - (AW + 1)'(1);
        end
        // Prefetch the entry that will be at the head next cycle for full-rate pops.
        ram_raddr  = rd_ptr_d;
        rd_valid_d = (count_d != '0);
        if (count_d == '0) begin
          state_d     = ST_IDLE;
          triggered_d = 1'b0;
        end
      end
    endcase

    if (abort) begin
      state_d     = ST_IDLE;
      count_d     = '0;
      rd_valid_d  = 1'b0;
      triggered_d = 1'b0;
      ram_we      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      triggered_q <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      triggered_q <= triggered_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  trace_ram #(
    .W     (RD_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (rd_data)
  );

  assign rd_valid  = rd_valid_q;
  assign state     = state_q;
  assign count     = count_q;
  assign triggered = triggered_q;

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Self-checking bench for pipeline_trace_buffer: table-driven capture steps plus a
// scoreboard of expected entries popped as the DUT drains. Define TRACE_TIMESTAMP_EN for stamp checks.
module tb_pipeline_trace_buffer;
  import pipeline_trace_pkg::*;

  localparam int PC_W   = 32;
  localparam int SNAP_W = 16;
  localparam int NS     = 4;
  localparam int DEPTH  = 16;
  localparam int CYC_W  = 16;
  localparam int AW     = 4;
  localparam int E_W    = PC_W + NS * SNAP_W;
`ifdef TRACE_TIMESTAMP_EN
  localparam int RD_W   = CYC_W + E_W;
`else
  localparam int RD_W   = E_W;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0, arm = 1'b0, abort = 1'b0, rd_ready = 1'b0;
  logic [PC_W-1:0]      pc = '0, trig_pc = '0;
  logic [NS*SNAP_W-1:0] stage_snap = '0;
  logic [1:0]           trig_mode = '0;
  logic [SNAP_W-1:0]    trig_mask = '0, trig_val = '0;
  logic [AW-1:0]        post_count = '0;
  logic                 rd_valid;
  logic [RD_W-1:0]      rd_data;
  logic [1:0]           state;
  logic [AW:0]          count;
  logic                 triggered;

  int errors = 0;
  int checks = 0;
  logic [E_W-1:0]   exp_q [$];
  logic [CYC_W-1:0] stamps [$];

  typedef struct {
    logic            en;
    logic [PC_W-1:0] pc;
    logic [1:0]      st;
    logic [AW:0]     cnt;
    logic            trg;
  } vec_t;
  vec_t vt [5];

  always #5 clk = ~clk;

  pipeline_trace_buffer #(
    .PC_W(PC_W), .SNAP_W(SNAP_W), .NUM_STAGES(NS), .DEPTH(DEPTH), .CYC_W(CYC_W)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .pc(pc), .stage_snap(stage_snap),
    .arm(arm), .abort(abort), .trig_mode(trig_mode), .trig_pc(trig_pc),
    .trig_mask(trig_mask), .trig_val(trig_val), .post_count(post_count),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .state(state), .count(count), .triggered(triggered)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [PC_W-1:0] p, input logic [NS*SNAP_W-1:0] s);
    enable     = en;
    pc         = p;
    stage_snap = s;
    if (en) exp_q.push_back({p, s});
    step();
    enable = 1'b0;
  endtask

  task automatic start_capture(input logic [1:0] mode, input logic [AW-1:0] post);
    trig_mode  = mode;
    post_count = post;
    exp_q.delete();
    arm    = 1'b1;
    enable = 1'b1;
    pc     = 32'hDEAD_0000;
    step();
    arm    = 1'b0;
    enable = 1'b0;
  endtask

  // Pops up to max_pops entries (<0 = until empty) and compares against the scoreboard.
  task automatic drain(input bit rand_rdy, input string tag, input int max_pops);
    int budget = 600;
    int pops   = 0;
    logic [E_W-1:0] e;
    while ((exp_q.size() != 0 || state != ST_IDLE) && budget > 0 &&
           (max_pops < 0 || pops < max_pops)) begin
      rd_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          check({tag, " extra"}, rd_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          $display("pop %s pc=%08h snap=%016h", tag, rd_data[E_W-1 -: PC_W], rd_data[NS*SNAP_W-1:0]);
          check({tag, " data"}, rd_data[E_W-1:0], e);
`ifdef TRACE_TIMESTAMP_EN
          stamps.push_back(rd_data[RD_W-1 -: CYC_W]);
`endif
        end
        pops++;
      end
      step();
      budget--;
    end
    rd_ready = 1'b0;
    if (max_pops < 0) begin
      check({tag, " left"}, 128'(exp_q.size()), 128'd0);
      check({tag, " idle"}, state, ST_IDLE);
      check({tag, " trig clr"}, triggered, 1'b0);
    end else begin
      check({tag, " pops"}, 128'(pops), 128'(max_pops));
    end
  endtask

  initial begin
    // Reset state
    #12;
    check("rst state", state, ST_IDLE);
    check("rst count", count, 0);
    check("rst valid", rd_valid, 1'b0);
    check("rst trig", triggered, 1'b0);
    check("rst data", rd_data, 0);
    reset = 1'b1;
    step();

    // 1: async reset mid-POST with count=7
    start_capture(TRIG_IMM, 4'd15);
    for (int i = 0; i < 7; i++) drive(1'b1, PC_W'(i * 4), {$urandom, $urandom});
    check("t1 pre state", state, ST_POST);
    check("t1 pre count", count, 7);
    #2 reset = 1'b0;
    #1;
    check("t1 async state", state, ST_IDLE);
    check("t1 async count", count, 0);
    check("t1 async valid", rd_valid, 1'b0);
    reset = 1'b1;
    step();

    // 2: immediate trigger, post_count=3, with a stall in the middle (table-driven)
    vt[0] = '{1'b1, 32'h0,  ST_POST,  5'd1, 1'b1};
    vt[1] = '{1'b1, 32'h4,  ST_POST,  5'd2, 1'b1};
    vt[2] = '{1'b0, 32'h99, ST_POST,  5'd2, 1'b1};
    vt[3] = '{1'b1, 32'h8,  ST_POST,  5'd3, 1'b1};
    vt[4] = '{1'b1, 32'hC,  ST_DRAIN, 5'd4, 1'b1};
    start_capture(TRIG_IMM, 4'd3);
    check("t2 armed", state, ST_ARMED);
    check("t2 arm no cap", count, 0);
    check("t2 arm no trig", triggered, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(vt[i].en, vt[i].pc, {$urandom, $urandom});
      check($sformatf("t2 v%0d state", i), state, vt[i].st);
      check($sformatf("t2 v%0d count", i), count, vt[i].cnt);
      check($sformatf("t2 v%0d trig", i), triggered, vt[i].trg);
    end
    check("t2 valid lat", rd_valid, 1'b0);
    drain(1'b0, "t2", -1);

    // 3: PC trigger after 30 enabled cycles, post 5 -> wrap, keep last 16
    trig_pc = 32'h40;
    start_capture(TRIG_PC, 4'd5);
    for (int i = 0; i < 30; i++) drive(1'b1, 32'h1000 + PC_W'(i * 4), {$urandom, $urandom});
    check("t3 still armed", state, ST_ARMED);
    check("t3 sat count", count, 16);
    drive(1'b1, 32'h40, {$urandom, $urandom});
    check("t3 trig", triggered, 1'b1);
    check("t3 post", state, ST_POST);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'h40, {$urandom, $urandom});
      drive(1'b1, 32'h2000 + PC_W'(i * 4), {$urandom, $urandom});
    end
    check("t3 drain", state, ST_DRAIN);
    check("t3 count", count, 16);
    while (exp_q.size() > DEPTH) void'(exp_q.pop_front());
    drain(1'b0, "t3", -1);

    // 4: snapshot trigger with enable toggling; match during stall is ignored
    trig_mask = 16'h00F0;
    trig_val  = 16'h0030;
    start_capture(TRIG_SNAP, 4'd2);
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) drive(1'b1, 32'h3000 + PC_W'(i * 4), {$urandom, 16'($urandom), 16'(i)});
      else            drive(1'b0, 32'h3000 + PC_W'(i * 4), {$urandom, 16'($urandom), 16'h0035});
    end
    check("t4 no trig", triggered, 1'b0);
    check("t4 armed", state, ST_ARMED);
    check("t4 count", count, 5);
    drive(1'b1, 32'h3100, {$urandom, 16'($urandom), 16'h1234});
    check("t4 trig", triggered, 1'b1);
    drive(1'b0, 32'h3104, {$urandom, $urandom});
    drive(1'b1, 32'h3108, {$urandom, $urandom});
    drive(1'b0, 32'h310C, {$urandom, $urandom});
    drive(1'b1, 32'h3110, {$urandom, $urandom});
    check("t4 drain", state, ST_DRAIN);
    check("t4 final count", count, 8);
    // 5a: random backpressure drain
    drain(1'b1, "t4", -1);

    // 5b: abort mid-drain
    start_capture(TRIG_IMM, 4'd7);
    for (int i = 0; i < 8; i++) drive(1'b1, 32'h5000 + PC_W'(i * 4), {$urandom, $urandom});
    check("t5 count", count, 8);
    drain(1'b0, "t5", 3);
    check("t5 mid count", count, 5);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t5 abort state", state, ST_IDLE);
    check("t5 abort valid", rd_valid, 1'b0);
    check("t5 abort count", count, 0);
    check("t5 abort trig", triggered, 1'b0);
    exp_q.delete();

    // abort wins over arm and over trigger
    arm = 1'b1; abort = 1'b1;
    step();
    arm = 1'b0; abort = 1'b0;
    check("abort>arm", state, ST_IDLE);
    start_capture(TRIG_IMM, 4'd3);
    enable = 1'b1; abort = 1'b1;
    step();
    enable = 1'b0; abort = 1'b0;
    check("abort>trig state", state, ST_IDLE);
    check("abort>trig trig", triggered, 1'b0);
    check("abort>trig count", count, 0);

    // never-trigger mode: saturation, and arm ignored outside IDLE
    start_capture(TRIG_NEVER, 4'd0);
    for (int i = 0; i < 20; i++) drive(1'b1, PC_W'(i), {$urandom, $urandom});
    check("never state", state, ST_ARMED);
    check("never count", count, 16);
    arm = 1'b1;
    step();
    arm = 1'b0;
    check("arm ignored", count, 16);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("never abort", state, ST_IDLE);
    exp_q.delete();

`ifdef TRACE_TIMESTAMP_EN
    // 6: stamps advance on stalled cycles too
    stamps.delete();
    start_capture(TRIG_IMM, 4'd1);
    drive(1'b1, 32'h500, {$urandom, $urandom});
    drive(1'b0, 32'h0,   {$urandom, $urandom});
    drive(1'b0, 32'h0,   {$urandom, $urandom});
    drive(1'b1, 32'h504, {$urandom, $urandom});
    check("t6 drain", state, ST_DRAIN);
    drain(1'b0, "t6", -1);
    if (stamps.size() == 2) check("t6 stamp diff", 128'(stamps[1] - stamps[0]), 128'd3);
    else                    check("t6 stamp pops", 128'(stamps.size()), 128'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
